bit_serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor. It is the multi-cycle successor to the single-bit full_adder cell.
- Latches two WIDTH-bit operands on a start handshake.
- Processes one bit per clock, LSB first, through a single full_adder plus a carry flip-flop.
- Reports sum/difference, carry-out and signed overflow with a one-cycle done pulse.
- Sits beside the other serial datapath blocks wherever area matters more than latency.

---
 rtl/bsa_pkg.sv | 10 +
 rtl/full_adder.sv | 13 +
 rtl/bit_serial_addsub.sv | 102 ++++++++++
 tb/tb_bit_serial_addsub.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: purely combinational, zero latency, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial A+B / A-B, LSB first through one full adder; done pulses WIDTH cycles after the start edge.
// No backpressure: start is accepted only in IDLE and is dropped (not queued) while busy or done.
module bit_serial_addsub
  import bsa_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  state_t state, next_state;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry, sub_q;
  logic [CNT_W-1:0] cnt;
  logic             bit_b, fa_sum, fa_co, last_bit;

  // Subtraction is A + ~B + 1: B is inverted bit by bit and the +1 is the carry preload.
  assign bit_b    = b_sr[0] ^ sub_q;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (bit_b),
    .c_in (carry),
    .sum  (fa_sum),
    .c_out(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            carry  <= sub;
            sub_q  <= sub;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry  <= fa_co;
          if (last_bit) begin
            cnt      <= '0;
            result   <= {fa_sum, sum_sr[WIDTH-1:1]};
            c_out    <= fa_co;
            // carry still holds the carry into the MSB during the last bit
            overflow <= carry ^ fa_co;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Directed and model-checked random vectors for bit_serial_addsub at WIDTH 8, 16 and 2.
module tb_bit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] a_bus, b_bus;
  int          sel;

  always #5 clk = ~clk;

  logic st8, st16, st2;
  assign st8  = start && (sel == 8);
  assign st16 = start && (sel == 16);
  assign st2  = start && (sel == 2);

  logic        busy8, done8, c8, ov8;
  logic [7:0]  res8;
  logic        busy16, done16, c16, ov16;
  logic [15:0] res16;
  logic        busy2, done2, c2, ov2;
  logic [1:0]  res2;

  bit_serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub),
    .a(a_bus[7:0]), .b(b_bus[7:0]),
    .busy(busy8), .done(done8), .result(res8), .c_out(c8), .overflow(ov8)
  );

  bit_serial_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub),
    .a(a_bus[15:0]), .b(b_bus[15:0]),
    .busy(busy16), .done(done16), .result(res16), .c_out(c16), .overflow(ov16)
  );

  bit_serial_addsub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .sub(sub),
    .a(a_bus[1:0]), .b(b_bus[1:0]),
    .busy(busy2), .done(done2), .result(res2), .c_out(c2), .overflow(ov2)
  );

  logic        obs_busy, obs_done, obs_c, obs_ov;
  logic [31:0] obs_res;

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_c    = c8;
    obs_ov   = ov8;
    obs_res  = {24'd0, res8};
    case (sel)
      16: begin
        obs_busy = busy16; obs_done = done16; obs_c = c16; obs_ov = ov16;
        obs_res  = {16'd0, res16};
      end
      2: begin
        obs_busy = busy2; obs_done = done2; obs_c = c2; obs_ov = ov2;
        obs_res  = {30'd0, res2};
      end
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, c_out, result} from plain wide integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic s,
                                        input logic [31:0] av, input logic [31:0] bv);
    logic [32:0] m, x, y, t, r;
    logic        sa, sb, sr, c, ov;
    m  = (33'd1 << w) - 33'd1;
    x  = {1'b0, av} & m;
    y  = (s ? ~{1'b0, bv} : {1'b0, bv}) & m;
    t  = x + y + {32'd0, s};
    r  = t & m;
    c  = t[w];
    sa = x[w-1];
    sb = y[w-1];
    sr = r[w-1];
    ov = (sa == sb) && (sr != sa);
    return {ov, c, r[31:0]};
  endfunction

  task automatic op(input string tag, input int w, input logic s,
                    input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] er, input logic ec, input logic eo);
    int          n;
    logic [31:0] prev;
    logic        held;
    sel = w;
    @(negedge clk);
    prev  = obs_res;
    a_bus = av;
    b_bus = bv;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy_run"}, {31'd0, obs_busy}, 32'd1);
    n    = 0;
    held = 1'b1;
    while (!obs_done && n < 100) begin
      if (obs_res !== prev) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".latency"}, n, w);
    chk({tag, ".held"}, {31'd0, held}, 32'd1);
    chk({tag, ".busy_done"}, {31'd0, obs_busy}, 32'd0);
    chk({tag, ".result"}, obs_res, er);
    chk({tag, ".c_out"}, {31'd0, obs_c}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, obs_ov}, {31'd0, eo});
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, {31'd0, obs_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ndone;
    logic [31:0] res_seen;
    logic [33:0] e;
    logic [31:0] av, bv;
    logic        s;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a_bus = '0;
    b_bus = '0;
    sel   = 8;
    #1;
    chk("rst.busy", {31'd0, obs_busy}, 32'd0);
    chk("rst.done", {31'd0, obs_done}, 32'd0);
    chk("rst.result", obs_res, 32'd0);
    chk("rst.c_out", {31'd0, obs_c}, 32'd0);
    chk("rst.ovf", {31'd0, obs_ov}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op("add5a33", 8, 1'b0, 32'h5A, 32'h33, 32'h8D, 1'b0, 1'b1);
    op("addff01", 8, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0);
    op("add8080", 8, 1'b0, 32'h80, 32'h80, 32'h00, 1'b1, 1'b1);
    op("sub1001", 8, 1'b1, 32'h10, 32'h01, 32'h0F, 1'b1, 1'b0);
    op("sub8001", 8, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);
    op("sub0001", 8, 1'b1, 32'h00, 32'h01, 32'hFF, 1'b0, 1'b0);

    // Start and operand changes during RUN must be ignored.
    sel = 8;
    @(negedge clk);
    a_bus = 32'h01; b_bus = 32'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_bus = 32'h7F; b_bus = 32'h55; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone    = 0;
    res_seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (obs_done) begin
        if (ndone == 0) res_seen = obs_res;
        ndone++;
      end
    end
    chk("ign.done_count", ndone, 32'd1);
    chk("ign.result", res_seen, 32'h02);

    // Mid-operation reset, with nonzero outputs held from the previous op.
    op("pre_rst", 8, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);
    @(negedge clk);
    a_bus = 32'h5A; b_bus = 32'h33; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", {31'd0, obs_busy}, 32'd0);
    chk("mid_rst.done", {31'd0, obs_done}, 32'd0);
    chk("mid_rst.result", obs_res, 32'd0);
    chk("mid_rst.c_out", {31'd0, obs_c}, 32'd0);
    chk("mid_rst.ovf", {31'd0, obs_ov}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (obs_done) ndone++;
    end
    chk("mid_rst.no_done", ndone, 32'd0);
    op("post_rst", 8, 1'b0, 32'h5A, 32'h33, 32'h8D, 1'b0, 1'b1);

    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 16 : 2;
      for (int i = 0; i < 200; i++) begin
        av = $urandom;
        bv = $urandom;
        s  = 1'($urandom_range(0, 1));
        e  = model(w, s, av, bv);
        op($sformatf("rnd%0d_%0d", w, i), w, s, av, bv, e[31:0], e[32], e[33]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
